// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared ALU control, ALUOp and funct7 encodings for the RV32 core
package core_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_I    = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - funct3/funct7/ALUOp to 4-bit ALU control decoder
module alu_ctrl_dec
  import core_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALUOP_LDST: alu_ctrl = ALU_ADD;
      ALUOP_BR:   alu_ctrl = ALU_SUB;
      ALUOP_R: begin
        case (funct3)
          3'b000: begin
            if (funct7 == F7_ALT)      alu_ctrl = ALU_SUB;
            else if (funct7 == F7_MUL) alu_ctrl = ALU_MUL;
            else                       alu_ctrl = ALU_ADD;
          end
          3'b111: alu_ctrl = ALU_AND;
          3'b110: alu_ctrl = ALU_OR;
          3'b100: alu_ctrl = ALU_XOR;
          3'b001: alu_ctrl = ALU_SLL;
          3'b101: alu_ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_ADD;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      ALUOP_I: begin
        case (funct3)
          3'b111: alu_ctrl = ALU_AND;
          3'b110: alu_ctrl = ALU_OR;
          3'b100: alu_ctrl = ALU_XOR;
          3'b001: alu_ctrl = ALU_SLL;
          3'b101: alu_ctrl = ALU_SRA;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU decode, operand forwarding and load-use detect
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [RA_W-1:0] rs1_addr_i,
  input  logic [RA_W-1:0] rs2_addr_i,
  input  logic [RA_W-1:0] rd_addr_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [1:0]      alu_op_i,
  input  logic            alu_src_i,
  input  logic            reg_write_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            mem_to_reg_i,
  input  logic            exmem_reg_write_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0] exmem_data_i,
  input  logic            memwb_reg_write_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic [XLEN-1:0] alu_data1_o,
  output logic [XLEN-1:0] alu_data2_o,
  output logic [3:0]      alu_ctrl_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [XLEN-1:0] pc_o,
  output logic [RA_W-1:0] rd_addr_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            valid_o,
  output logic            load_use_o
);

  logic [3:0]      alu_ctrl_d;
  logic [3:0]      alu_ctrl_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [RA_W-1:0] rs1_addr_q, rs2_addr_q, rd_q;
  logic            valid_q, alu_src_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op   (alu_op_i),
    .funct3   (funct3_i),
    .funct7   (funct7_i),
    .alu_ctrl (alu_ctrl_d)
  );

  // Flush only kills the control bits; data fields keep whatever they held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      alu_src_q    <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_q         <= '0;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
    end else if (!stall_i) begin
      valid_q      <= valid_i;
      reg_write_q  <= reg_write_i;
      mem_read_q   <= mem_read_i;
      mem_write_q  <= mem_write_i;
      mem_to_reg_q <= mem_to_reg_i;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_src_q    <= alu_src_i;
      pc_q         <= pc_i;
      rs1_data_q   <= rs1_data_i;
      rs2_data_q   <= rs2_data_i;
      imm_q        <= imm_i;
      rs1_addr_q   <= rs1_addr_i;
      rs2_addr_q   <= rs2_addr_i;
      rd_q         <= rd_addr_i;
    end
  end

  function automatic logic [XLEN-1:0] forward(
    input logic [RA_W-1:0] addr,
    input logic [XLEN-1:0] reg_data,
    input logic            ex_we,
    input logic [RA_W-1:0] ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_we,
    input logic [RA_W-1:0] wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (ex_we && ex_rd != '0 && ex_rd == addr)      return ex_data;
    else if (wb_we && wb_rd != '0 && wb_rd == addr) return wb_data;
    else                                            return reg_data;
  endfunction

  always_comb begin
    fwd_rs1 = forward(rs1_addr_q, rs1_data_q, exmem_reg_write_i, exmem_rd_i, exmem_data_i,
                      memwb_reg_write_i, memwb_rd_i, memwb_data_i);
    fwd_rs2 = forward(rs2_addr_q, rs2_data_q, exmem_reg_write_i, exmem_rd_i, exmem_data_i,
                      memwb_reg_write_i, memwb_rd_i, memwb_data_i);
  end

  assign alu_data1_o  = fwd_rs1;
  assign store_data_o = fwd_rs2;
  assign alu_data2_o  = alu_src_q ? imm_q : fwd_rs2;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign pc_o         = pc_q;
  assign rd_addr_o    = rd_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign valid_o      = valid_q;

  // A load in EX whose result the instruction in ID needs cannot be forwarded in time.
  assign load_use_o = valid_q & mem_read_q & (rd_q != '0) &
                      ((rd_q == rs1_addr_i) | (rd_q == rs2_addr_i));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [1:0]  alu_op_i;
  logic        alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic [31:0] alu_data1_o, alu_data2_o, store_data_o, pc_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, load_use_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .alu_op_i(alu_op_i), .alu_src_i(alu_src_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_to_reg_i(mem_to_reg_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .store_data_o(store_data_o), .pc_o(pc_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .valid_o(valid_o), .load_use_o(load_use_o)
  );

  // Model of what the EX stage holds: the instruction last accepted, or a bubble.
  typedef struct {
    bit          valid, rw, mr, mw, mtr, src, known;
    bit [3:0]    ctrl;
    bit [31:0]   pc, r1, r2, imm;
    bit [4:0]    rs1a, rs2a, rd;
  } ex_t;
  ex_t m;

  function automatic bit [3:0] ref_ctrl(input bit [1:0] op, input bit [2:0] f3, input bit [6:0] f7);
    bit [3:0] by_f3 [8];
    by_f3 = '{4'd2, 4'd4, 4'd2, 4'd2, 4'd3, 4'd7, 4'd1, 4'd0};
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return by_f3[f3];
    if (f3 == 3'd0) return (f7 == 7'h20) ? 4'd6 : (f7 == 7'h01) ? 4'd5 : 4'd2;
    if (f3 == 3'd5) return (f7 == 7'h20) ? 4'd7 : 4'd2;
    return by_f3[f3];
  endfunction

  function automatic bit [31:0] ref_fwd(input bit [4:0] a, input bit [31:0] d);
    if (exmem_reg_write_i && exmem_rd_i != 0 && exmem_rd_i == a) return exmem_data_i;
    if (memwb_reg_write_i && memwb_rd_i != 0 && memwb_rd_i == a) return memwb_data_i;
    return d;
  endfunction

  task automatic model_update();
    if (rst_i) begin
      m = '{default: 0};
      m.ctrl = 4'd2;
      m.known = 1;
    end else if (flush_i) begin
      {m.valid, m.rw, m.mr, m.mw, m.mtr} = '0;
      m.ctrl = 4'd2;
      m.known = 0;
    end else if (!stall_i) begin
      m.valid = valid_i; m.rw = reg_write_i; m.mr = mem_read_i; m.mw = mem_write_i;
      m.mtr = mem_to_reg_i; m.src = alu_src_i; m.ctrl = ref_ctrl(alu_op_i, funct3_i, funct7_i);
      m.pc = pc_i; m.r1 = rs1_data_i; m.r2 = rs2_data_i; m.imm = imm_i;
      m.rs1a = rs1_addr_i; m.rs2a = rs2_addr_i; m.rd = rd_addr_i; m.known = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit lu;
    lu = m.valid && m.mr && m.rd != 0 && (m.rd == rs1_addr_i || m.rd == rs2_addr_i);
    chk("valid", valid_o, m.valid);
    chk("reg_write", reg_write_o, m.rw);
    chk("mem_read", mem_read_o, m.mr);
    chk("mem_write", mem_write_o, m.mw);
    chk("mem_to_reg", mem_to_reg_o, m.mtr);
    chk("alu_ctrl", alu_ctrl_o, m.ctrl);
    chk("load_use", load_use_o, lu);
    if (m.known) begin
      chk("pc", pc_o, m.pc);
      chk("rd_addr", rd_addr_o, m.rd);
      chk("alu_data1", alu_data1_o, ref_fwd(m.rs1a, m.r1));
      chk("store_data", store_data_o, ref_fwd(m.rs2a, m.r2));
      chk("alu_data2", alu_data2_o, m.src ? m.imm : ref_fwd(m.rs2a, m.r2));
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
    #1 check_all();
  endtask

  task automatic settle();
    #1 check_all();
  endtask

  task automatic drive_idle();
    {stall_i, flush_i, valid_i, alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i} = '0;
    {pc_i, rs1_data_i, rs2_data_i, imm_i} = '0;
    {rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7_i, alu_op_i} = '0;
    {exmem_reg_write_i, memwb_reg_write_i, exmem_rd_i, memwb_rd_i} = '0;
    exmem_data_i = '0; memwb_data_i = '0;
  endtask

  task automatic drive_rand();
    bit [6:0] f7s [4];
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    f7s[3] = 7'($urandom);
    valid_i = 1'($urandom); alu_src_i = 1'($urandom); reg_write_i = 1'($urandom);
    mem_read_i = 1'($urandom); mem_write_i = 1'($urandom); mem_to_reg_i = 1'($urandom);
    pc_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
    rs1_addr_i = 5'($urandom_range(0, 7)); rs2_addr_i = 5'($urandom_range(0, 7));
    rd_addr_i = 5'($urandom_range(0, 7));
    alu_op_i = 2'($urandom); funct3_i = 3'($urandom); funct7_i = f7s[$urandom_range(0, 3)];
    exmem_reg_write_i = 1'($urandom); memwb_reg_write_i = 1'($urandom);
    exmem_rd_i = 5'($urandom_range(0, 7)); memwb_rd_i = 5'($urandom_range(0, 7));
    exmem_data_i = $urandom; memwb_data_i = $urandom;
  endtask

  // {alu_op, funct3, funct7, expected code}
  typedef struct { bit [1:0] op; bit [2:0] f3; bit [6:0] f7; bit [3:0] code; } sweep_t;
  sweep_t sweep [] = '{
    '{2'b00, 3'b111, 7'h20, 4'b0010}, '{2'b01, 3'b000, 7'h00, 4'b0110},
    '{2'b10, 3'b000, 7'h00, 4'b0010}, '{2'b10, 3'b000, 7'h20, 4'b0110},
    '{2'b10, 3'b000, 7'h01, 4'b0101}, '{2'b10, 3'b111, 7'h00, 4'b0000},
    '{2'b10, 3'b110, 7'h00, 4'b0001}, '{2'b10, 3'b100, 7'h00, 4'b0011},
    '{2'b10, 3'b001, 7'h00, 4'b0100}, '{2'b10, 3'b101, 7'h20, 4'b0111},
    '{2'b10, 3'b101, 7'h00, 4'b0010}, '{2'b10, 3'b010, 7'h00, 4'b0010},
    '{2'b11, 3'b000, 7'h00, 4'b0010}, '{2'b11, 3'b111, 7'h00, 4'b0000},
    '{2'b11, 3'b110, 7'h00, 4'b0001}, '{2'b11, 3'b100, 7'h00, 4'b0011},
    '{2'b11, 3'b001, 7'h00, 4'b0100}, '{2'b11, 3'b101, 7'h20, 4'b0111},
    '{2'b11, 3'b011, 7'h00, 4'b0010}
  };

  initial begin
    drive_idle();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    settle();
    chk("rst_valid", valid_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_data1", alu_data1_o, 0);
    chk("rst_alu_ctrl", alu_ctrl_o, 4'b0010);
    chk("rst_load_use", load_use_o, 0);

    // R-type SUB
    valid_i = 1; reg_write_i = 1; alu_op_i = 2'b10; funct7_i = 7'h20;
    rs1_addr_i = 1; rs2_addr_i = 2; rd_addr_i = 6; rs1_data_i = 9; rs2_data_i = 4;
    step();
    chk("sub_ctrl", alu_ctrl_o, 4'b0110);
    chk("sub_data1", alu_data1_o, 9);
    chk("sub_data2", alu_data2_o, 4);

    // Forwarding priority
    drive_idle(); valid_i = 1; rs1_addr_i = 5; rs1_data_i = 32'h11;
    step();
    exmem_reg_write_i = 1; exmem_rd_i = 5; exmem_data_i = 32'hAA;
    memwb_reg_write_i = 1; memwb_rd_i = 5; memwb_data_i = 32'hBB;
    settle();
    chk("fwd_exmem", alu_data1_o, 32'hAA);
    exmem_reg_write_i = 0;
    settle();
    chk("fwd_memwb", alu_data1_o, 32'hBB);

    // x0 is never forwarded
    drive_idle(); valid_i = 1; rs2_addr_i = 0; rs2_data_i = 0;
    step();
    exmem_reg_write_i = 1; exmem_rd_i = 0; exmem_data_i = 32'hFF;
    settle();
    chk("x0_guard", store_data_o, 0);

    // Load-use then flush
    drive_idle(); valid_i = 1; mem_read_i = 1; reg_write_i = 1; mem_to_reg_i = 1; rd_addr_i = 3;
    step();
    rs1_addr_i = 1; rs2_addr_i = 3;
    settle();
    chk("load_use_hit", load_use_o, 1);
    flush_i = 1;
    step();
    flush_i = 0;
    chk("flush_valid", valid_o, 0);
    chk("flush_reg_write", reg_write_o, 0);
    chk("flush_alu_ctrl", alu_ctrl_o, 4'b0010);

    // Stall holds srai, then stall+flush bubbles
    drive_idle(); valid_i = 1; reg_write_i = 1; alu_op_i = 2'b11; funct3_i = 3'b101;
    funct7_i = 7'h20; imm_i = 2; alu_src_i = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      stall_i = 1; flush_i = 0;
      step();
      chk("stall_ctrl", alu_ctrl_o, 4'b0111);
      chk("stall_data2", alu_data2_o, 2);
      chk("stall_valid", valid_o, 1);
    end
    stall_i = 1; flush_i = 1;
    step();
    chk("stallflush_valid", valid_o, 0);
    chk("stallflush_ctrl", alu_ctrl_o, 4'b0010);

    // Decode sweep
    foreach (sweep[k]) begin
      drive_idle(); valid_i = 1;
      alu_op_i = sweep[k].op; funct3_i = sweep[k].f3; funct7_i = sweep[k].f7;
      step();
      chk($sformatf("sweep_%0d", k), alu_ctrl_o, sweep[k].code);
    end

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive_rand();
      stall_i = ($urandom_range(0, 5) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      rst_i   = ($urandom_range(0, 59) == 0);
      step();
      settle();
    end
    rst_i = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32 core, sitting directly upstream of the EX-stage ALU.
- Registers decoded ID fields and decodes funct3/funct7/ALUOp into the 4-bit ALU control code.
- Applies EX/MEM and MEM/WB forwarding to the ALU operands.
- Detects load-use hazards, supports stall (hold) and flush (bubble insert).

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- stall_i  in  1  hold stage contents
- flush_i  in  1  replace next contents with bubble
- valid_i  in  1  ID holds a real instruction
- pc_i  in  XLEN  ID program counter
- rs1_data_i  in  XLEN  register-file read data
- rs2_data_i  in  XLEN  register-file read data
- imm_i  in  XLEN  sign-extended immediate
- rs1_addr_i  in  RA_W  source register address
- rs2_addr_i  in  RA_W  source register address
- rd_addr_i  in  RA_W  destination register address
- funct3_i  in  3  instruction funct3
- funct7_i  in  7  instruction funct7
- alu_op_i  in  2  00 ld/st, 01 branch, 10 R-type, 11 I-type ALU
- alu_src_i  in  1  1 selects imm as operand 2
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1 each  control bits
- exmem_reg_write_i  in  1  EX/MEM writes a register
- exmem_rd_i  in  RA_W  EX/MEM destination
- exmem_data_i  in  XLEN  EX/MEM ALU result
- memwb_reg_write_i  in  1  MEM/WB writes a register
- memwb_rd_i  in  RA_W  MEM/WB destination
- memwb_data_i  in  XLEN  MEM/WB writeback data
- alu_data1_o  out  XLEN  ALU operand 1
- alu_data2_o  out  XLEN  ALU operand 2
- alu_ctrl_o  out  4  ALU control code
- store_data_o  out  XLEN  forwarded rs2 for stores
- pc_o  out  XLEN  registered PC
- rd_addr_o  out  RA_W  registered destination
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1 each  registered control
- valid_o  out  1  EX holds a real instruction
- load_use_o  out  1  combinational stall request to hazard logic

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high.
- Reset values: all registered fields 0 and alu_ctrl_q = ADD (0010), i.e. a bubble. Outputs are therefore 0, alu_ctrl_o = 0010, and load_use_o = 0.
- Latency: ID inputs appear on outputs 1 cycle after the capturing edge.
- Update priority per edge: rst_i > flush_i > stall_i > capture.
  - flush_i: clears valid, reg_write, mem_read, mem_write and mem_to_reg, and sets alu_ctrl to ADD. Data fields may hold any value.
  - stall_i without flush_i: every register holds.
  - Flush and stall together: flush wins.
- ALU control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, MUL 0101, SUB 0110, SRA 0111. Decoded from ID inputs before the register.
  - alu_op 00 -> ADD.
  - alu_op 01 -> SUB.
  - alu_op 10, by funct3/funct7:
    - 000/0000000 ADD; 000/0100000 SUB; 000/0000001 MUL
    - 111 AND; 110 OR; 100 XOR; 001 SLL; 101/0100000 SRA
  - alu_op 11, by funct3: 000 ADD, 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRA.
  - Any unlisted combination -> ADD.
- Forwarding: combinational, from registered rs1/rs2 addresses.
  - EX/MEM is selected when exmem_reg_write_i is set, exmem_rd_i != 0 and exmem_rd_i matches.
  - Otherwise MEM/WB is selected under the same rule.
  - Otherwise register data is used.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand outputs:
  - alu_data1_o = forwarded rs1.
  - store_data_o = forwarded rs2.
  - alu_data2_o = alu_src_q ? imm_q : forwarded rs2.
- Load-use: load_use_o = valid_q & mem_read_q & rd_q != 0 & (rd_q == rs1_addr_i | rd_q == rs2_addr_i).
  - The hazard unit answers with flush_i to this stage plus a stall of IF/ID.
- Outputs depend only on registered state and the forwarding inputs, never directly on ID inputs. The exception is load_use_o, which also depends on rs1_addr_i and rs2_addr_i.

Decomposition:
- Package core_pkg holds:
  - ALU control localparams (ALU_AND … ALU_SRA)
  - ALUOp encodings (ALUOP_LDST, ALUOP_BR, ALUOP_R, ALUOP_I)
  - funct7 constants (F7_BASE 0000000, F7_ALT 0100000, F7_MUL 0000001)
- Sub-module alu_ctrl_dec: the combinational funct3/funct7/alu_op -> 4-bit code decoder, instantiated once before the register.

Test Plan:
- Reset and decode: hold rst_i 2 cycles, then release and check all outputs 0 with alu_ctrl_o = 0010. Next, drive R-type funct3 000 / funct7 0100000 with rs1 = 9, rs2 = 4 -> one cycle later alu_ctrl_o = 0110, data1 = 9, data2 = 4.
- Forwarding priority: EX rs1 = 5; exmem rd = 5, data = 0xAA, write = 1; memwb rd = 5, data = 0xBB, write = 1 -> alu_data1_o = 0xAA. Clear exmem_reg_write_i -> alu_data1_o = 0xBB.
- x0 guard: rs2 = 0 and exmem rd = 0, write = 1, data = 0xFF -> store_data_o = rs2 register data (0), not 0xFF.
- Load-use: EX holds lw x3 (mem_read = 1, valid = 1) and ID rs2 = 3 -> load_use_o = 1. Assert flush_i -> next cycle valid_o = 0, reg_write_o = 0, alu_ctrl_o = 0010.
- Stall/flush interplay: stall_i with srai, imm = 2, alu_src = 1 captured -> outputs hold for 3 cycles with alu_ctrl_o = 0111 and alu_data2_o = 2. Then stall_i and flush_i together -> bubble.
- Decode sweep: every alu_op/funct3/funct7 entry yields the listed code. alu_op 10 with funct3 010 -> 0010.
